// File: rtl/fmps_trip_scanner_pkg.sv
// Shared definitions for the FMPS trip scanner: scan states, control-word
// field positions and status-word layout.
package fmps_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_EVAL  = 2'd3
  } scan_state_e;

  // Control word: trip mask occupies [trip_width-1:0], flags sit just above it.
  localparam int CSR_MASK_LSB = 0;

  function automatic int csr_failsafe_bit(input int trip_width);
    return trip_width;
  endfunction

  function automatic int csr_clear_bit(input int trip_width);
    return trip_width + 1;
  endfunction

  localparam int STAT_SCAN_ACTIVE = 31;
  localparam int STAT_TRIP        = 30;
  localparam int STAT_FAILSAFE    = 29;
  localparam int STAT_OVERRUN     = 28;
  localparam int STAT_FFI_LSB     = 16;
  localparam int STAT_MASK_LSB    = 0;

endpackage

// File: rtl/fmps_trip_scanner_if.sv
// Signal bundle between the gather stage / CSR block and the trip scanner.
interface fmps_trip_scanner_if #(
  parameter int INDEX_WIDTH = 5
);
  localparam int NODES = 1 << INDEX_WIDTH;

  logic                   FAstrobe;
  logic                   readoutValid;
  logic                   sysTimeoutStrobe;
  logic [INDEX_WIDTH:0]   fmpsCount;
  logic [NODES-1:0]       fmpsBitmapEnabled;
  logic [INDEX_WIDTH-1:0] fmpsReadoutAddress;
  logic [31:0]            fmpsReadout;
  logic                   fmpsReadoutPresent;
  logic                   csrStrobe;
  logic [31:0]            GPIO_OUT;
  logic                   mitigationTrip;
  logic [NODES-1:0]       tripBitmap;
  logic [NODES-1:0]       missingBitmap;
  logic [INDEX_WIDTH-1:0] firstFaultIndex;
  logic                   scanDoneStrobe;
  logic                   overrunStrobe;
  logic [31:0]            status;

  modport slave (
    input  FAstrobe, readoutValid, sysTimeoutStrobe, fmpsCount, fmpsBitmapEnabled,
    input  fmpsReadout, fmpsReadoutPresent, csrStrobe, GPIO_OUT,
    output fmpsReadoutAddress, mitigationTrip, tripBitmap, missingBitmap,
    output firstFaultIndex, scanDoneStrobe, overrunStrobe, status
  );

  modport master (
    output FAstrobe, readoutValid, sysTimeoutStrobe, fmpsCount, fmpsBitmapEnabled,
    output fmpsReadout, fmpsReadoutPresent, csrStrobe, GPIO_OUT,
    input  fmpsReadoutAddress, mitigationTrip, tripBitmap, missingBitmap,
    input  firstFaultIndex, scanDoneStrobe, overrunStrobe, status
  );

endinterface

// File: rtl/fmps_priority_encoder.sv
// Lowest-set-bit encoder: returns the index of the least significant request.
module fmps_priority_encoder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]                                 req_i,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]     idx_o,
  output logic                                             valid_o
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fmps_trip_scanner.sv
// Sweeps the gathered FMPS DPRAM after each readout, builds trip/missing
// bitmaps and latches a mitigation trip with the first faulting node.
module fmps_trip_scanner
  import fmps_pkg::*;
#(
  parameter int INDEX_WIDTH = 5,
  parameter int TRIP_WIDTH  = 8
) (
  input logic                sysClk,
  input logic                sysReset,
  fmps_trip_scanner_if.slave bus
);
  localparam int NODES   = 1 << INDEX_WIDTH;
  localparam int CW      = INDEX_WIDTH + 1;
  localparam int FS_BIT  = csr_failsafe_bit(TRIP_WIDTH);
  localparam int CLR_BIT = csr_clear_bit(TRIP_WIDTH);

  scan_state_e            state_q, state_d;
  logic                   rv_q;
  logic [CW-1:0]          cnt_q, cnt_d, n_q, n_sat;
  logic                   cap_q;
  logic [INDEX_WIDTH-1:0] cap_addr_q;
  logic [NODES-1:0]       work_trip_q, work_trip_d, work_miss_q, work_miss_d;
  logic [NODES-1:0]       trip_bm_q, miss_bm_q;
  logic [TRIP_WIDTH-1:0]  mask_q;
  logic                   failsafe_q;
  logic                   trip_q, trip_d;
  logic [INDEX_WIDTH-1:0] ffi_q, ffi_d;
  logic                   sticky_q, sticky_d;
  logic                   done_q, overrun_q;
  logic                   start, abort, eval_go, csr_clear, eval_set, timeout_set;
  logic [NODES-1:0]       fault_vec;
  logic [INDEX_WIDTH-1:0] enc_idx;
  logic                   enc_valid;
  logic [31:0]            status_w;
  logic                   unused_bits;

  assign start     = (state_q == ST_IDLE) & bus.readoutValid & ~rv_q;
  assign abort     = bus.FAstrobe & (state_q != ST_IDLE);
  assign n_sat     = (bus.fmpsCount > CW'(NODES)) ? CW'(NODES) : bus.fmpsCount;
  assign eval_go   = (state_q == ST_EVAL) & ~abort;
  assign csr_clear = bus.csrStrobe & bus.GPIO_OUT[CLR_BIT];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (n_sat == '0) ? ST_EVAL : ST_SCAN;
      ST_SCAN:  if (cnt_q == n_q - CW'(1)) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_EVAL;
      ST_EVAL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Counter rests at zero outside SCAN so the address port is quiet between scans.
  assign cnt_d = (state_q == ST_SCAN && state_d == ST_SCAN) ? cnt_q + CW'(1) : '0;

  always_comb begin
    work_trip_d = work_trip_q;
    work_miss_d = work_miss_q;
    if (start) begin
      work_trip_d = '0;
      work_miss_d = '0;
    end else if (cap_q) begin
      if (!bus.fmpsReadoutPresent)
        work_miss_d[cap_addr_q] = 1'b1;
      else if (bus.fmpsBitmapEnabled[cap_addr_q] &&
               |(bus.fmpsReadout[TRIP_WIDTH-1:0] & mask_q))
        work_trip_d[cap_addr_q] = 1'b1;
    end
  end

  assign fault_vec = work_trip_q | (failsafe_q ? work_miss_q : '0);

  fmps_priority_encoder #(.WIDTH(NODES)) u_first_fault (
    .req_i   (fault_vec),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign eval_set    = eval_go & enc_valid & ~trip_q;
  assign timeout_set = failsafe_q & (bus.sysTimeoutStrobe | abort);

  // Clear is applied first so that any trip set in the same cycle survives it.
  always_comb begin
    trip_d   = trip_q;
    ffi_d    = ffi_q;
    sticky_d = sticky_q;
    if (csr_clear) begin
      trip_d   = 1'b0;
      ffi_d    = '0;
      sticky_d = 1'b0;
    end
    if (abort) sticky_d = 1'b1;
    if (eval_set) begin
      trip_d = 1'b1;
      ffi_d  = enc_idx;
    end else if (timeout_set) begin
      trip_d = 1'b1;
      ffi_d  = trip_q ? ffi_q : '1;
    end
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      rv_q        <= 1'b0;
      cnt_q       <= '0;
      n_q         <= '0;
      cap_q       <= 1'b0;
      cap_addr_q  <= '0;
      work_trip_q <= '0;
      work_miss_q <= '0;
      trip_bm_q   <= '0;
      miss_bm_q   <= '0;
      mask_q      <= '0;
      failsafe_q  <= 1'b0;
      trip_q      <= 1'b0;
      ffi_q       <= '0;
      sticky_q    <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rv_q        <= bus.readoutValid;
      cnt_q       <= cnt_d;
      cap_q       <= (state_q == ST_SCAN);
      cap_addr_q  <= cnt_q[INDEX_WIDTH-1:0];
      work_trip_q <= work_trip_d;
      work_miss_q <= work_miss_d;
      trip_q      <= trip_d;
      ffi_q       <= ffi_d;
      sticky_q    <= sticky_d;
      done_q      <= eval_go;
      overrun_q   <= abort;
      if (start) n_q <= n_sat;
      if (eval_go) begin
        trip_bm_q <= work_trip_q;
        miss_bm_q <= work_miss_q;
      end
      if (bus.csrStrobe) begin
        mask_q     <= bus.GPIO_OUT[CSR_MASK_LSB +: TRIP_WIDTH];
        failsafe_q <= bus.GPIO_OUT[FS_BIT];
      end
    end
  end

  always_comb begin
    status_w                                 = '0;
    status_w[STAT_SCAN_ACTIVE]               = (state_q != ST_IDLE);
    status_w[STAT_TRIP]                      = trip_q;
    status_w[STAT_FAILSAFE]                  = failsafe_q;
    status_w[STAT_OVERRUN]                   = sticky_q;
    status_w[STAT_FFI_LSB +: INDEX_WIDTH]    = ffi_q;
    status_w[STAT_MASK_LSB +: TRIP_WIDTH]    = mask_q;
  end

  assign bus.fmpsReadoutAddress = cnt_q[INDEX_WIDTH-1:0];
  assign bus.mitigationTrip     = trip_q;
  assign bus.tripBitmap         = trip_bm_q;
  assign bus.missingBitmap      = miss_bm_q;
  assign bus.firstFaultIndex    = ffi_q;
  assign bus.scanDoneStrobe     = done_q;
  assign bus.overrunStrobe      = overrun_q;
  assign bus.status             = status_w;

  assign unused_bits = ^{bus.GPIO_OUT[31:CLR_BIT+1], bus.fmpsReadout[31:TRIP_WIDTH]};

endmodule

// File: tb/tb_fmps_trip_scanner.sv
// Randomised and directed bench for fmps_trip_scanner against a node-level model.
module tb_fmps_trip_scanner;

  logic sysClk = 1'b0;
  logic sysReset;

  fmps_trip_scanner_if #(.INDEX_WIDTH(5)) bus ();

  fmps_trip_scanner #(.INDEX_WIDTH(5), .TRIP_WIDTH(8)) dut (
    .sysClk   (sysClk),
    .sysReset (sysReset),
    .bus      (bus)
  );

  always #5 sysClk = ~sysClk;

  logic [31:0] mem [32];
  bit          pres [32];
  logic [31:0] enabled;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  logic        m_trip, m_fs, m_sticky;
  logic [4:0]  m_ffi;
  logic [7:0]  m_mask;
  logic [31:0] m_tbm, m_mbm;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
  endtask

  // DPRAM stand-in: data for the address seen in one cycle appears in the next.
  initial begin : dpram
    logic [4:0] a;
    bus.fmpsReadout        = '0;
    bus.fmpsReadoutPresent = 1'b0;
    forever begin
      @(negedge sysClk);
      a = bus.fmpsReadoutAddress;
      @(posedge sysClk);
      #1;
      bus.fmpsReadout        = mem[a];
      bus.fmpsReadoutPresent = pres[a];
    end
  end

  initial forever begin
    @(negedge sysClk);
    if (bus.scanDoneStrobe === 1'b1) n_done++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  function automatic logic [31:0] exp_status();
    return {1'b0, m_trip, m_fs, m_sticky, 4'b0, 3'b0, m_ffi, 8'b0, m_mask};
  endfunction

  task automatic csr_write(input logic [7:0] mask, input logic fs, input logic clr);
    bus.GPIO_OUT  = {22'd0, clr, fs, mask};
    bus.csrStrobe = 1'b1;
    tick();
    bus.csrStrobe = 1'b0;
    bus.GPIO_OUT  = '0;
    m_mask = mask;
    m_fs   = fs;
    if (clr) begin
      m_trip   = 1'b0;
      m_ffi    = '0;
      m_sticky = 1'b0;
    end
  endtask

  task automatic model_scan(input int n);
    int ns;
    logic [31:0] fault;
    ns    = (n > 32) ? 32 : n;
    m_tbm = '0;
    m_mbm = '0;
    for (int i = 0; i < ns; i++) begin
      if (!pres[i]) m_mbm[i] = 1'b1;
      else if (enabled[i] && ((mem[i][7:0] & m_mask) != 8'h00)) m_tbm[i] = 1'b1;
    end
    fault = m_tbm | (m_fs ? m_mbm : 32'h0);
    if (fault != 0 && !m_trip) begin
      m_trip = 1'b1;
      for (int i = 31; i >= 0; i--) if (fault[i]) m_ffi = 5'(i);
    end
  endtask

  task automatic run_scan(input int n, input bit addr_each, input string tag);
    int lat, ns, exp_lat;
    bit addr_ok;
    ns      = (n > 32) ? 32 : n;
    exp_lat = (ns == 0) ? 2 : ns + 3;
    bus.fmpsCount         = 6'(n);
    bus.fmpsBitmapEnabled = enabled;
    bus.readoutValid      = 1'b1;
    lat     = 0;
    addr_ok = 1'b1;
    while (lat < 100) begin
      tick();
      lat++;
      if (lat <= ns) begin
        if (bus.fmpsReadoutAddress !== 5'(lat - 1)) addr_ok = 1'b0;
        if (addr_each) check_val({tag, ":addr"}, 32'(bus.fmpsReadoutAddress), 32'(lat - 1));
      end else if (bus.fmpsReadoutAddress !== 5'd0) addr_ok = 1'b0;
      if (bus.scanDoneStrobe === 1'b1) break;
    end
    bus.readoutValid = 1'b0;
    model_scan(n);
    check_val({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, ":addr_seq"}, 32'(addr_ok), 32'd1);
    check_val({tag, ":tripBitmap"}, bus.tripBitmap, m_tbm);
    check_val({tag, ":missingBitmap"}, bus.missingBitmap, m_mbm);
    check_val({tag, ":trip"}, 32'(bus.mitigationTrip), 32'(m_trip));
    check_val({tag, ":ffi"}, 32'(bus.firstFaultIndex), 32'(m_ffi));
    check_val({tag, ":status"}, bus.status, exp_status());
    tick();
  endtask

  task automatic fill_clean();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = '0;
      pres[i] = 1'b1;
    end
    enabled = '1;
  endtask

  initial begin
    int done_before;
    logic [31:0] tbm_before, mbm_before;

    sysReset = 1'b1;
    bus.FAstrobe = 1'b0;  bus.readoutValid = 1'b0;  bus.sysTimeoutStrobe = 1'b0;
    bus.fmpsCount = '0;   bus.fmpsBitmapEnabled = '0;
    bus.csrStrobe = 1'b0; bus.GPIO_OUT = '0;
    m_trip = 0; m_fs = 0; m_sticky = 0; m_ffi = 0; m_mask = 0; m_tbm = 0; m_mbm = 0;
    fill_clean();
    repeat (3) @(posedge sysClk);
    #1 sysReset = 1'b0;
    check_val("rst:trip", 32'(bus.mitigationTrip), 32'd0);
    check_val("rst:tripBitmap", bus.tripBitmap, 32'd0);
    check_val("rst:status", bus.status, 32'd0);
    check_val("rst:done", 32'(bus.scanDoneStrobe), 32'd0);
    tick();

    csr_write(8'hFF, 1'b0, 1'b0);
    run_scan(4, 1'b1, "clean4");

    mem[5] = 32'h04;  mem[2] = 32'h10;
    csr_write(8'h14, 1'b0, 1'b0);
    run_scan(8, 1'b0, "trip8");
    mem[5] = '0;  mem[2] = '0;
    run_scan(8, 1'b0, "sticky8");
    csr_write(8'h14, 1'b0, 1'b1);
    check_val("clear:trip", 32'(bus.mitigationTrip), 32'd0);
    check_val("clear:ffi", 32'(bus.firstFaultIndex), 32'd0);

    mem[3] = 32'hFF;  enabled[3] = 1'b0;
    csr_write(8'hFF, 1'b0, 1'b0);
    run_scan(8, 1'b0, "disabled");
    fill_clean();

    pres[4] = 1'b0;
    run_scan(6, 1'b0, "miss_nofs");
    csr_write(8'hFF, 1'b1, 1'b0);
    run_scan(6, 1'b0, "miss_fs");
    fill_clean();
    csr_write(8'hFF, 1'b0, 1'b1);

    bus.sysTimeoutStrobe = 1'b1;  tick();  bus.sysTimeoutStrobe = 1'b0;
    check_val("timeout_nofs:trip", 32'(bus.mitigationTrip), 32'd0);
    csr_write(8'hFF, 1'b1, 1'b0);
    bus.sysTimeoutStrobe = 1'b1;  tick();  bus.sysTimeoutStrobe = 1'b0;
    m_trip = 1'b1;  m_ffi = 5'h1F;
    check_val("timeout_fs:trip", 32'(bus.mitigationTrip), 32'd1);
    check_val("timeout_fs:ffi", 32'(bus.firstFaultIndex), 32'h1F);
    csr_write(8'hFF, 1'b1, 1'b1);

    tbm_before  = bus.tripBitmap;
    mbm_before  = bus.missingBitmap;
    done_before = n_done;
    bus.fmpsCount = 6'd16;
    bus.readoutValid = 1'b1;
    repeat (3) tick();
    bus.FAstrobe = 1'b1;  tick();  bus.FAstrobe = 1'b0;
    m_trip = 1'b1;  m_ffi = 5'h1F;  m_sticky = 1'b1;
    check_val("abort:overrun", 32'(bus.overrunStrobe), 32'd1);
    tick();
    check_val("abort:overrun_pulse", 32'(bus.overrunStrobe), 32'd0);
    repeat (20) tick();
    bus.readoutValid = 1'b0;
    check_val("abort:no_done", 32'(n_done), 32'(done_before));
    check_val("abort:tripBitmap", bus.tripBitmap, tbm_before);
    check_val("abort:missingBitmap", bus.missingBitmap, mbm_before);
    check_val("abort:trip", 32'(bus.mitigationTrip), 32'd1);
    check_val("abort:ffi", 32'(bus.firstFaultIndex), 32'h1F);
    check_val("abort:status", bus.status, exp_status());
    tick();

    bus.readoutValid = 1'b1;
    repeat (3) tick();
    sysReset = 1'b1;
    #1;
    check_val("midrst:trip", 32'(bus.mitigationTrip), 32'd0);
    check_val("midrst:status", bus.status, 32'd0);
    check_val("midrst:tripBitmap", bus.tripBitmap, 32'd0);
    check_val("midrst:ffi", 32'(bus.firstFaultIndex), 32'd0);
    bus.readoutValid = 1'b0;
    tick();
    sysReset = 1'b0;
    m_trip = 0; m_fs = 0; m_sticky = 0; m_ffi = 0; m_mask = 0;
    tick();

    run_scan(0, 1'b0, "zero");

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 32; i++) begin
        mem[i]  = ($urandom_range(0, 6) == 0) ? $urandom : ($urandom & 32'hFFFF_FF00);
        pres[i] = ($urandom_range(0, 15) != 0);
      end
      enabled = $urandom;
      csr_write(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      run_scan(int'($urandom_range(0, 40)), 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fmps_trip_scanner.md
Name: fmps_trip_scanner

Overview:
- Downstream consumer of the FMPS link-gather stage, in the sysClk domain.
- On each completed FA-cycle readout, sweeps the gathered FMPS DPRAM over its readout address/data port and evaluates per-node trip flags against a mask.
- Produces a latched mitigation trip, a per-node trip bitmap and the first-faulting node index.
- Feeds the Mitigation Node logic and the microBlaze status registers.

Parameters:
- INDEX_WIDTH, 5, width of FMPS node index; up to 2**INDEX_WIDTH nodes.
- TRIP_WIDTH, 8, number of trip flag bits in FMPS data word bits [TRIP_WIDTH-1:0].

Ports:
- sysClk  in  1  system clock.
- sysReset  in  1  asynchronous, active-high reset.
- FAstrobe  in  1  fast-acquisition cycle start pulse.
- readoutValid  in  1  level from gather stage; a rising edge starts a scan.
- sysTimeoutStrobe  in  1  gather-stage readout timeout pulse.
- fmpsCount  in  INDEX_WIDTH+1  number of nodes to scan.
- fmpsBitmapEnabled  in  2**INDEX_WIDTH  nodes reporting enabled in this cycle.
- fmpsReadoutAddress  out  INDEX_WIDTH  DPRAM read address.
- fmpsReadout  in  32  DPRAM data; 1-cycle latency after address.
- fmpsReadoutPresent  in  1  qualifies fmpsReadout; same latency as fmpsReadout.
- csrStrobe  in  1  control write strobe.
- GPIO_OUT  in  32  control write data:
  - [TRIP_WIDTH-1:0] tripMask
  - [TRIP_WIDTH] failsafeEnable
  - [TRIP_WIDTH+1] clearLatch (self-clearing)
- mitigationTrip  out  1  latched trip.
- tripBitmap  out  2**INDEX_WIDTH  nodes tripped in last completed scan.
- missingBitmap  out  2**INDEX_WIDTH  scanned nodes not present.
- firstFaultIndex  out  INDEX_WIDTH  lowest tripped/missing index, latched with the trip.
- scanDoneStrobe  out  1  one-cycle pulse at end of evaluation.
- overrunStrobe  out  1  pulse when FAstrobe aborts an in-progress scan.
- status  out  32  {scanActive, mitigationTrip, failsafeEnable, overrunSticky, 4'b0, firstFaultIndex zero-extended to 8, tripMask zero-extended to 16}.

Behaviour:
- Reset: all outputs 0; tripMask=0, failsafeEnable=0, overrunSticky=0; state IDLE.
- Start detect: readoutValid registered once; a rising edge in IDLE enters SCAN. Rising edges seen outside IDLE are ignored.
- IDLE -> SCAN:
  - address counter=0; working trip/missing bitmaps cleared.
  - If fmpsCount==0, go directly to EVAL.
- SCAN:
  - Drive fmpsReadoutAddress=counter, increment each cycle.
  - After issuing address fmpsCount-1, go to DRAIN.
- DRAIN: one cycle, to capture the last data beat; then EVAL.
- Data capture, every cycle one cycle after address A was issued:
  - If fmpsReadoutPresent is 0: set missing[A].
  - Else if fmpsBitmapEnabled[A] and (fmpsReadout[TRIP_WIDTH-1:0] & tripMask) != 0: set trip[A].
  - Nodes present but not enabled never trip.
- fmpsCount > 2**INDEX_WIDTH is saturated to 2**INDEX_WIDTH. The address counter is INDEX_WIDTH+1 bits wide; the low bits drive the port.
- EVAL (one cycle):
  - Copy working bitmaps to tripBitmap/missingBitmap.
  - fault = |trip | (failsafeEnable & |missing).
  - If fault and !mitigationTrip: set mitigationTrip and load firstFaultIndex with the lowest set index of (trip | (failsafeEnable ? missing : 0)), via priority encoder.
  - Pulse scanDoneStrobe; return to IDLE.
- sysTimeoutStrobe: if failsafeEnable, set mitigationTrip (firstFaultIndex unchanged if already tripped; else all ones). Ignored otherwise.
- FAstrobe while in SCAN/DRAIN/EVAL:
  - Abort to IDLE and pulse overrunStrobe; set overrunSticky.
  - Output bitmaps are not updated.
  - If failsafeEnable, treat as timeout trip.
- FAstrobe in IDLE: no effect.
- Control writes:
  - csrStrobe loads tripMask and failsafeEnable.
  - If clearLatch=1: clear mitigationTrip, firstFaultIndex and overrunSticky.
  - A clear in the same cycle as a new trip set: set wins.
- Latency: scanDoneStrobe asserts fmpsCount+3 cycles after the readoutValid rising edge (1 edge-detect cycle, N address cycles, DRAIN, EVAL).
- mitigationTrip remains set until clearLatch; later clean scans do not clear it.

Decomposition:
- Shared package fmps_pkg:
  - GPIO_OUT control field positions.
  - State encoding (IDLE, SCAN, DRAIN, EVAL).
  - status field offsets.
- Sub-module fmps_priority_encoder (parameter WIDTH): lowest-set-bit index plus valid flag; combinational, registered in the parent's EVAL.

Test Plan:
- fmpsCount=4, all present/enabled, data trip bits 0, tripMask=8'hFF, rising readoutValid -> scanDoneStrobe at cycle 7 after edge, tripBitmap=0, mitigationTrip=0, addresses 0,1,2,3 in successive cycles.
- fmpsCount=8, node 5 data=32'h04, node 2 data=32'h10, tripMask=8'h14 -> tripBitmap=32'h24, mitigationTrip=1, firstFaultIndex=2; next clean scan leaves trip=1 and index=2; clearLatch write -> both 0.
- Node 3 present with data 32'hFF but fmpsBitmapEnabled[3]=0, tripMask=8'hFF -> no trip, tripBitmap=0.
- fmpsCount=6, node 4 not present: failsafeEnable=0 -> missingBitmap=32'h10, no trip; failsafeEnable=1 -> trip, firstFaultIndex=4.
- FAstrobe two cycles into a 16-node scan with failsafeEnable=1 -> overrunStrobe pulse, no scanDoneStrobe, bitmaps unchanged, mitigationTrip=1, firstFaultIndex=5'h1F; assert sysReset mid-scan -> all outputs 0, state IDLE.
- fmpsCount=0 -> scanDoneStrobe 2 cycles after edge, no address activity beyond 0, no trip.
